// File: rtl/fdiv_pkg.sv
// Shared types and constants for the run-time clock divider controller.
`timescale 1ns/1ps
package fdiv_pkg;
    localparam int CNT_W_DEF   = 8;
    localparam int DEF_DIV_DEF = 4;
    localparam int MIN_DIV     = 2;

    typedef enum logic [1:0] {
        STOP   = 2'd0,
        RUN    = 2'd1,
        SWITCH = 2'd2
    } fdiv_state_e;
endpackage

// File: rtl/fdiv_ctrl_if.sv
// Ratio request/acknowledge bundle between the requester and the divider controller.
`timescale 1ns/1ps
interface fdiv_ctrl_if
    import fdiv_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             div_req;
    logic [CNT_W-1:0] div_in;
    logic             div_ack;
    logic             div_err;
    logic             busy;
    logic [CNT_W-1:0] cur_div;

    modport master (output div_req, div_in, input div_ack, div_err, busy, cur_div);
    modport slave  (input div_req, div_in, output div_ack, div_err, busy, cur_div);
endinterface

// File: rtl/fdiv_core.sv
// Period counter: produces registered fout/tick and flags the last cycle of a period.
`timescale 1ns/1ps
module fdiv_core
    import fdiv_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic             fin,
    input  logic             rst,
    input  logic             en,
    input  logic [CNT_W-1:0] div_n,
    input  logic [CNT_W-1:0] div_hold,
    output logic             wrap,
    output logic             fout,
    output logic             tick
);
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             fout_q, fout_d, tick_q, tick_d;

    assign wrap = (cnt_q == div_n - CNT_W'(1));

    always_comb begin
        cnt_inc = wrap ? '0 : cnt_q + CNT_W'(1);
        // Stopping only ever takes effect on the last cycle of a period, so no runt pulse.
        if (en || !wrap) begin
            cnt_d  = cnt_inc;
            fout_d = (cnt_inc < (div_n >> 1));
            tick_d = (cnt_inc == div_n - CNT_W'(1));
        end else begin
            cnt_d  = div_hold - CNT_W'(1);
            fout_d = 1'b0;
            tick_d = 1'b0;
        end
    end

    always_ff @(posedge fin or negedge rst) begin
        if (!rst) begin
            cnt_q  <= CNT_W'(DEF_DIV - 1);
            fout_q <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            fout_q <= fout_d;
            tick_q <= tick_d;
        end
    end

    assign fout = fout_q;
    assign tick = tick_q;
endmodule

// File: rtl/fdiv_ctrl.sv
// Divider controller: FSM, pending ratio and request handshake around one fdiv_core.
`timescale 1ns/1ps
module fdiv_ctrl
    import fdiv_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int DEF_DIV = DEF_DIV_DEF
) (
    input  logic      fin,
    input  logic      rst,
    input  logic      en,
    fdiv_ctrl_if.slave bus,
    output logic      fout,
    output logic      tick
);
    fdiv_state_e      state_q, state_d;
    logic [CNT_W-1:0] cur_div_q, cur_div_d, pend_q, pend_d;
    logic             ack_q, ack_d, err_q, err_d, busy_q, busy_d;
    logic             wrap, req_fire, req_ok;

    // A request is not sampled while its predecessor is being acknowledged or one is pending.
    assign req_fire = bus.div_req && !ack_q && (state_q != SWITCH);
    assign req_ok   = (bus.div_in >= CNT_W'(MIN_DIV));

    fdiv_core #(
        .CNT_W   (CNT_W),
        .DEF_DIV (DEF_DIV)
    ) u_core (
        .fin      (fin),
        .rst      (rst),
        .en       (en),
        .div_n    (cur_div_q),
        .div_hold (cur_div_d),
        .wrap     (wrap),
        .fout     (fout),
        .tick     (tick)
    );

    always_ff @(posedge fin or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            cur_div_q <= CNT_W'(DEF_DIV);
            pend_q    <= '0;
            ack_q     <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_div_q <= cur_div_d;
            pend_q    <= pend_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            STOP:    state_d = en ? RUN : STOP;
            RUN: begin
                if (wrap && !en)             state_d = STOP;
                else if (req_fire && req_ok) state_d = SWITCH;
            end
            SWITCH:  if (wrap) state_d = en ? RUN : STOP;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        cur_div_d = cur_div_q;
        pend_d    = pend_q;
        ack_d     = 1'b0;
        err_d     = 1'b0;
        if (req_fire && !req_ok) begin
            ack_d = 1'b1;
            err_d = 1'b1;
        end
        case (state_q)
            STOP: begin
                if (req_fire && req_ok) begin
                    cur_div_d = bus.div_in;
                    ack_d     = 1'b1;
                end
            end
            RUN:     if (state_d == SWITCH) pend_d = bus.div_in;
            SWITCH: begin
                if (wrap) begin
                    cur_div_d = pend_q;
                    ack_d     = 1'b1;
                end
            end
            default: ;
        endcase
        busy_d = (state_d == SWITCH);
    end

    assign bus.div_ack = ack_q;
    assign bus.div_err = err_q;
    assign bus.busy    = busy_q;
    assign bus.cur_div = cur_div_q;
endmodule
